// File: rtl/vc_fifo_if.sv
// vc_fifo_if: push/pop handshake and status bundle between a virtual-channel
// FIFO (slave) and the logic that feeds and drains it (master).
interface vc_fifo_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  error;

  modport master (
    output push, data_in, pop,
    input  data_out, empty, full, almost_full, almost_empty, error
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, empty, full, almost_full, almost_empty, error
  );
endinterface

// File: rtl/vc_fifo.sv
// vc_fifo: per-virtual-channel word FIFO in the transmit path.
// Flags are decoded from a registered occupancy count; read data and error are
// registered. Build option: define VC_FIFO_STICKY_ERROR_EN to make `error`
// latch until reset; otherwise it pulses for one cycle per offending request.
module vc_fifo #(
  parameter int DATA_WIDTH      = 6,
  parameter int ADDR_WIDTH      = 2,
  parameter int ALMOST_FULL_TH  = 3,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic        clk,
  input  logic        reset,
  vc_fifo_if.slave    fifo
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_TH_C  = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0]   AE_TH_C  = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  error_q, error_d;

  logic empty_s;
  logic full_s;
  logic push_ok_s;
  logic pop_ok_s;
  logic overflow_s;
  logic underflow_s;

  // Status decode and request qualification; a push into a full FIFO is only
  // legal when a pop frees a slot in the same cycle.
  always_comb begin
    empty_s     = (count_q == {(ADDR_WIDTH+1){1'b0}});
    full_s      = (count_q == DEPTH_C);
    pop_ok_s    = fifo.pop & ~empty_s;
    push_ok_s   = fifo.push & (~full_s | pop_ok_s);
    overflow_s  = fifo.push & full_s & ~pop_ok_s;
    underflow_s = fifo.pop & empty_s;
  end

  // Next-state for pointers, occupancy, read data and error flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    error_d    = error_q;

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE_C;
      data_out_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE_C;
      2'b01:   count_d = count_q - CNT_ONE_C;
      default: count_d = count_q;
    endcase

`ifdef VC_FIFO_STICKY_ERROR_EN
    error_d = error_q | overflow_s | underflow_s;
`else
    error_d = overflow_s | underflow_s;
`endif
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q   <= {ADDR_WIDTH{1'b0}};
      count_q    <= {(ADDR_WIDTH+1){1'b0}};
      data_out_q <= {DATA_WIDTH{1'b0}};
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      error_q    <= error_d;
    end
  end

  // Storage array; contents survive reset, writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok_s) begin
      mem_q[wr_ptr_q] <= fifo.data_in;
    end
  end

  assign fifo.data_out     = data_out_q;
  assign fifo.empty        = empty_s;
  assign fifo.full         = full_s;
  assign fifo.almost_full  = (count_q >= AF_TH_C);
  assign fifo.almost_empty = (count_q <= AE_TH_C);
  assign fifo.error        = error_q;

endmodule
